// File: rtl/cdma_burst_seq.sv
// CDMA burst sequencer: splits a descriptor into AXI-legal, 4 KB-safe burst commands,
// bounds in-flight bursts and gathers completion status for the register block.
module cdma_burst_seq #(
  parameter int unsigned ADDR_WDTH   = 32,
  parameter int unsigned LEN_WDTH    = 32,
  parameter int unsigned BEAT_BYTES  = 32,
  parameter int unsigned MAX_OUTSTD  = 4,
  parameter int unsigned DGBCNT_WDTH = 32
) (
  input  logic                   lb_clk,
  input  logic                   lb_rst,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  input  logic [ADDR_WDTH-1:0]   cfg_src_addr,
  input  logic [ADDR_WDTH-1:0]   cfg_dst_addr,
  input  logic [LEN_WDTH-1:0]    cfg_xfer_bytes,
  input  logic [7:0]             cfg_burst_len,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [ADDR_WDTH-1:0]   cmd_src_addr,
  output logic [ADDR_WDTH-1:0]   cmd_dst_addr,
  output logic [7:0]             cmd_len,
  input  logic                   cmp_valid,
  input  logic                   cmp_err,
  output logic                   sts_busy,
  output logic                   sts_done,
  output logic                   sts_err,
  output logic                   sts_abort,
  output logic [DGBCNT_WDTH-1:0] sts_burst_cnt,
  output logic [DGBCNT_WDTH-1:0] sts_err_cnt
);

  localparam int unsigned OFS = $clog2(BEAT_BYTES);
  localparam logic [ADDR_WDTH-1:0] AddrMask = ~ADDR_WDTH'(BEAT_BYTES - 1);
  localparam logic [3:0] MaxOut = 4'(MAX_OUTSTD);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCalc  = 3'd1;
  localparam logic [2:0] StIssue = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [ADDR_WDTH-1:0]   src_q, src_d, dst_q, dst_d;
  logic [LEN_WDTH-1:0]    rem_q, rem_d;
  logic [7:0]             blen_q, blen_d, len_q, len_d;
  logic [3:0]             outstd_q, outstd_d;
  logic                   abort_q, abort_d;
  logic                   err_q, err_d, sabort_q, sabort_d;
  logic [DGBCNT_WDTH-1:0] burst_cnt_q, burst_cnt_d, err_cnt_q, err_cnt_d;

  logic                 busy, hs, cmp_dec, abort_in, abort_any;
  logic [8:0]           beats;
  logic [ADDR_WDTH-1:0] addr_step;
  logic [12:0]          lim_rem, lim_bl, lim_src, lim_dst, lim_ab, lim_cd, beats_c;

  assign busy      = (state_q != StIdle);
  assign hs        = (state_q == StIssue) && cmd_ready;
  assign cmp_dec   = busy && cmp_valid && (outstd_q != 4'd0);
  assign abort_in  = cfg_abort &&
                     ((state_q == StCalc) || (state_q == StIssue) || (state_q == StWait));
  assign abort_any = abort_q || abort_in;
  assign beats     = 9'(len_q) + 9'd1;
  assign addr_step = ADDR_WDTH'(beats) << OFS;

  // Burst size is the tightest of remaining work, burst length and both 4 KB page ends.
  always_comb begin
    lim_rem = (rem_q > LEN_WDTH'(256)) ? 13'd256 : 13'(rem_q);
    lim_bl  = 13'(blen_q) + 13'd1;
    lim_src = (13'd4096 - {1'b0, src_q[11:0]}) >> OFS;
    lim_dst = (13'd4096 - {1'b0, dst_q[11:0]}) >> OFS;
    lim_ab  = (lim_rem < lim_bl) ? lim_rem : lim_bl;
    lim_cd  = (lim_src < lim_dst) ? lim_src : lim_dst;
    beats_c = (lim_ab < lim_cd) ? lim_ab : lim_cd;
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    blen_d      = blen_q;
    len_d       = len_q;
    outstd_d    = outstd_q;
    abort_d     = abort_q;
    err_d       = err_q;
    sabort_d    = sabort_q;
    burst_cnt_d = burst_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (abort_in) begin
      abort_d  = 1'b1;
      sabort_d = 1'b1;
    end

    // A completion coinciding with a handshake leaves the count unchanged.
    if (hs && !cmp_dec)      outstd_d = outstd_q + 4'd1;
    else if (!hs && cmp_dec) outstd_d = outstd_q - 4'd1;

    // Stray completions (idle or nothing outstanding) are flagged as errors.
    if (cmp_valid && (cmp_err || !busy || (outstd_q == 4'd0))) err_d = 1'b1;
    if (busy && cmp_valid && cmp_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + DGBCNT_WDTH'(1);
    end

    if (hs) begin
      src_d = src_q + addr_step;
      dst_d = dst_q + addr_step;
      rem_d = rem_q - LEN_WDTH'(beats);
      if (burst_cnt_q != '1) burst_cnt_d = burst_cnt_q + DGBCNT_WDTH'(1);
    end

    case (state_q)
      StIdle: begin
        if (cfg_start) begin
          src_d       = cfg_src_addr & AddrMask;
          dst_d       = cfg_dst_addr & AddrMask;
          rem_d       = cfg_xfer_bytes >> OFS;
          blen_d      = cfg_burst_len;
          outstd_d    = 4'd0;
          abort_d     = 1'b0;
          err_d       = 1'b0;
          sabort_d    = 1'b0;
          burst_cnt_d = '0;
          err_cnt_d   = '0;
          state_d     = StCalc;
        end
      end
      StCalc: begin
        if (rem_q == '0) begin
          state_d = StDone;
        end else if (abort_any) begin
          state_d = StWait;
        end else begin
          len_d   = 8'(beats_c - 13'd1);
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (hs) begin
          if ((rem_d != '0) && !abort_any && (outstd_d < MaxOut)) state_d = StCalc;
          else                                                    state_d = StWait;
        end
      end
      StWait: begin
        if ((outstd_q < MaxOut) && (rem_q != '0) && !abort_any) state_d = StCalc;
        else if (outstd_q == 4'd0)                              state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge lb_clk) begin
    if (lb_rst) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      blen_q      <= 8'd255;
      len_q       <= '0;
      outstd_q    <= '0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      sabort_q    <= 1'b0;
      burst_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      blen_q      <= blen_d;
      len_q       <= len_d;
      outstd_q    <= outstd_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      sabort_q    <= sabort_d;
      burst_cnt_q <= burst_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_valid     = (state_q == StIssue);
  assign cmd_src_addr  = src_q;
  assign cmd_dst_addr  = dst_q;
  assign cmd_len       = len_q;
  assign sts_busy      = busy;
  assign sts_done      = (state_q == StDone);
  assign sts_err       = err_q;
  assign sts_abort     = sabort_q;
  assign sts_burst_cnt = burst_cnt_q;
  assign sts_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cdma_burst_seq.sv
// Directed bench for cdma_burst_seq: burst splitting, 4 KB crossing, outstanding limit,
// zero length, error/simultaneity, abort and mid-transfer reset.
module tb_cdma_burst_seq;

  logic        lb_clk = 1'b0;
  logic        lb_rst = 1'b1;
  logic        cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [31:0] cfg_src_addr = '0, cfg_dst_addr = '0, cfg_xfer_bytes = '0;
  logic [7:0]  cfg_burst_len = 8'd255;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [31:0] cmd_src_addr, cmd_dst_addr;
  logic [7:0]  cmd_len;
  logic        cmp_valid = 1'b0, cmp_err = 1'b0;
  logic        sts_busy, sts_done, sts_err, sts_abort;
  logic [31:0] sts_burst_cnt, sts_err_cnt;

  always #5 lb_clk = ~lb_clk;

  cdma_burst_seq #(
    .ADDR_WDTH(32), .LEN_WDTH(32), .BEAT_BYTES(32), .MAX_OUTSTD(4), .DGBCNT_WDTH(32)
  ) dut (
    .lb_clk(lb_clk), .lb_rst(lb_rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
    .cfg_xfer_bytes(cfg_xfer_bytes), .cfg_burst_len(cfg_burst_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src_addr(cmd_src_addr),
    .cmd_dst_addr(cmd_dst_addr), .cmd_len(cmd_len), .cmp_valid(cmp_valid),
    .cmp_err(cmp_err), .sts_busy(sts_busy), .sts_done(sts_done), .sts_err(sts_err),
    .sts_abort(sts_abort), .sts_burst_cnt(sts_burst_cnt), .sts_err_cnt(sts_err_cnt)
  );

  int checks = 0, failures = 0;
  int cyc = 0, cmp_delay = 5, err_idx = 0, cmp_n = 0;
  bit auto_cmp = 1'b0;
  int due_q[$];
  logic [31:0] hs_src[$], hs_dst[$];
  logic [7:0]  hs_len[$];
  int hs_cnt = 0, done_cnt = 0, cmp_cnt = 0, outst_m = 0, outst_max = 0, coinc = 0;

  // Observer on the falling edge: records what the next rising edge will consume.
  always @(negedge lb_clk) begin
    if (lb_rst) begin
      outst_m = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        hs_src.push_back(cmd_src_addr);
        hs_dst.push_back(cmd_dst_addr);
        hs_len.push_back(cmd_len);
        hs_cnt++;
        due_q.push_back(cyc + 1 + cmp_delay);
        if (!cmp_valid) outst_m++;
        else            coinc++;
      end else if (cmp_valid && outst_m > 0) begin
        outst_m--;
      end
      if (cmp_valid) cmp_cnt++;
      if (sts_done) done_cnt++;
      if (outst_m > outst_max) outst_max = outst_m;
    end
  end

  task automatic step();
    @(posedge lb_clk);
    #1;
    cyc++;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cmp_valid = 1'b0;
    cmp_err   = 1'b0;
    if (auto_cmp && due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      cmp_n++;
      cmp_valid = 1'b1;
      cmp_err   = (cmp_n == err_idx);
    end
  endtask

  task automatic clear_stats();
    hs_src.delete(); hs_dst.delete(); hs_len.delete(); due_q.delete();
    hs_cnt = 0; done_cnt = 0; cmp_cnt = 0; outst_max = 0; cmp_n = 0; coinc = 0;
  endtask

  task automatic do_reset();
    lb_rst = 1'b1; cmd_ready = 1'b0; auto_cmp = 1'b0;
    repeat (3) step();
    lb_rst = 1'b0;
    clear_stats();
    step();
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n,
                       input logic [7:0] bl);
    cfg_src_addr = s; cfg_dst_addr = d; cfg_xfer_bytes = n; cfg_burst_len = bl;
    cfg_start = 1'b1;
    step();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      failures++;
      $display("FAIL %s_done: no done pulse within %0d cycles, required one", name, budget);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (cmd_valid !== 1'b0) begin failures++;
      $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
    checks++; if (sts_busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy: got %b want 0", sts_busy); end
    checks++; if ({sts_done, sts_err, sts_abort} !== 3'b000) begin failures++;
      $display("FAIL reset_flags: got %b want 000", {sts_done, sts_err, sts_abort}); end
    checks++; if ({sts_burst_cnt, sts_err_cnt} !== 64'd0) begin failures++;
      $display("FAIL reset_cnts: got %0h/%0h want 0/0", sts_burst_cnt, sts_err_cnt); end
    checks++; if ({cmd_src_addr, cmd_dst_addr, cmd_len} !== 72'd0) begin failures++;
      $display("FAIL reset_cmd: got %0h %0h %0h want 0", cmd_src_addr, cmd_dst_addr, cmd_len);
    end
    lb_rst = 1'b0;
    clear_stats();
    step();
  endtask

  task automatic test_4k_split();
    clear_stats();
    auto_cmp = 1'b1; cmp_delay = 5; err_idx = 0; cmd_ready = 1'b1;
    start(32'h3000_0000, 32'h1000_0000, 32'h4000, 8'd255);
    checks++; if (cmd_valid !== 1'b0 || sts_busy !== 1'b1) begin failures++;
      $display("FAIL split_calc: valid/busy got %b%b want 01", cmd_valid, sts_busy); end
    step();
    checks++; if (cmd_valid !== 1'b1) begin failures++;
      $display("FAIL split_first_valid: got %b want 1", cmd_valid); end
    wait_done("split", 400);
    checks++; if (hs_cnt !== 4) begin failures++;
      $display("FAIL split_count: got %0d want 4", hs_cnt); end
    for (int i = 0; i < hs_src.size(); i++) begin
      logic [31:0] es, ed;
      es = 32'h3000_0000 + 32'(i) * 32'h1000;
      ed = 32'h1000_0000 + 32'(i) * 32'h1000;
      checks++;
      if (hs_len[i] !== 8'd127 || hs_src[i] !== es || hs_dst[i] !== ed) begin failures++;
        $display("FAIL split_cmd%0d: got len=%0d src=%h dst=%h want len=127 src=%h dst=%h",
                 i, hs_len[i], hs_src[i], hs_dst[i], es, ed);
      end
    end
    repeat (3) step();
    checks++; if (done_cnt !== 1 || sts_busy !== 1'b0) begin failures++;
      $display("FAIL split_done_once: done=%0d busy=%b want 1/0", done_cnt, sts_busy); end
    checks++; if (sts_burst_cnt !== 32'd4 || sts_err !== 1'b0) begin failures++;
      $display("FAIL split_sts: burst_cnt=%0d err=%b want 4/0", sts_burst_cnt, sts_err); end
  endtask

  task automatic test_4k_cross();
    clear_stats();
    auto_cmp = 1'b1; cmp_delay = 5; cmd_ready = 1'b1;
    start(32'h3000_0F80, 32'h1000_0000, 32'h200, 8'd255);
    wait_done("cross", 200);
    checks++; if (hs_cnt !== 2) begin failures++;
      $display("FAIL cross_count: got %0d want 2", hs_cnt); end
    if (hs_cnt == 2) begin
      checks++;
      if (hs_len[0] !== 8'd3 || hs_src[0] !== 32'h3000_0F80 || hs_dst[0] !== 32'h1000_0000)
      begin failures++;
        $display("FAIL cross_cmd0: got len=%0d src=%h dst=%h want 3 30000f80 10000000",
                 hs_len[0], hs_src[0], hs_dst[0]);
      end
      checks++;
      if (hs_len[1] !== 8'd11 || hs_src[1] !== 32'h3000_1000 || hs_dst[1] !== 32'h1000_0080)
      begin failures++;
        $display("FAIL cross_cmd1: got len=%0d src=%h dst=%h want 11 30001000 10000080",
                 hs_len[1], hs_src[1], hs_dst[1]);
      end
    end
  endtask

  task automatic test_outstanding();
    int seen = 0;
    clear_stats();
    auto_cmp = 1'b0; cmd_ready = 1'b1;
    start(32'h0000_0000, 32'h0001_0000, 32'h2000, 8'd15);
    repeat (30) step();
    checks++; if (hs_cnt !== 4 || cmd_valid !== 1'b0 || sts_busy !== 1'b1) begin failures++;
      $display("FAIL outstd_limit: accepted=%0d valid=%b busy=%b want 4/0/1",
               hs_cnt, cmd_valid, sts_busy);
    end
    cmp_valid = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      if (cmd_valid === 1'b1) seen = 1;
    end
    checks++; if (seen !== 1) begin failures++;
      $display("FAIL outstd_resume: cmd_valid seen=%0d want 1 within 3 cycles", seen); end
    repeat (8) step();
    checks++; if (hs_cnt !== 5 || outst_max !== 4) begin failures++;
      $display("FAIL outstd_fifth: accepted=%0d max_out=%0d want 5/4", hs_cnt, outst_max); end
    do_reset();
  endtask

  task automatic test_zero_len();
    clear_stats();
    cmd_ready = 1'b1;
    start(32'h0000_0040, 32'h0000_0080, 32'h1F, 8'd255);
    checks++; if (sts_done !== 1'b0) begin failures++;
      $display("FAIL zero_done_early: got %b want 0", sts_done); end
    step();
    checks++; if (sts_done !== 1'b1) begin failures++;
      $display("FAIL zero_done: got %b want 1", sts_done); end
    step();
    checks++; if (hs_cnt !== 0 || sts_burst_cnt !== 32'd0 || done_cnt !== 1) begin failures++;
      $display("FAIL zero_sts: cmds=%0d burst_cnt=%0d done=%0d want 0/0/1",
               hs_cnt, sts_burst_cnt, done_cnt);
    end
  endtask

  task automatic test_err_simul();
    clear_stats();
    auto_cmp = 1'b1; cmp_delay = 1; err_idx = 2; cmd_ready = 1'b1;
    start(32'h0000_2000, 32'h0000_8000, 32'h1000, 8'd31);
    wait_done("errsim", 200);
    checks++; if (hs_cnt !== 4 || cmp_cnt !== 4 || sts_burst_cnt !== 32'd4) begin failures++;
      $display("FAIL errsim_count: cmds=%0d cmps=%0d burst_cnt=%0d want 4/4/4",
               hs_cnt, cmp_cnt, sts_burst_cnt);
    end
    checks++; if (sts_err !== 1'b1 || sts_err_cnt !== 32'd1) begin failures++;
      $display("FAIL errsim_err: err=%b err_cnt=%0d want 1/1", sts_err, sts_err_cnt); end
    checks++; if (coinc < 1 || outst_max > 4) begin failures++;
      $display("FAIL errsim_simul: coincident=%0d max_out=%0d want >=1/<=4", coinc, outst_max);
    end
    auto_cmp = 1'b0; err_idx = 0;
  endtask

  task automatic test_abort();
    clear_stats();
    auto_cmp = 1'b0; cmd_ready = 1'b0;
    start(32'h2000_0000, 32'h4000_0000, 32'h2000, 8'd15);
    checks++; if (sts_err !== 1'b0) begin failures++;
      $display("FAIL abort_err_clear: got %b want 0", sts_err); end
    step();
    cfg_abort = 1'b1;
    step();
    checks++; if (sts_abort !== 1'b1) begin failures++;
      $display("FAIL abort_flag: got %b want 1", sts_abort); end
    repeat (3) step();
    checks++; if (cmd_valid !== 1'b1 || cmd_src_addr !== 32'h2000_0000) begin failures++;
      $display("FAIL abort_hold: valid=%b src=%h want 1 20000000", cmd_valid, cmd_src_addr);
    end
    auto_cmp = 1'b1; cmp_delay = 3; cmd_ready = 1'b1;
    wait_done("abort", 100);
    repeat (5) step();
    checks++; if (hs_cnt !== 1 || cmp_cnt !== 1 || sts_burst_cnt !== 32'd1) begin failures++;
      $display("FAIL abort_drain: cmds=%0d cmps=%0d burst_cnt=%0d want 1/1/1",
               hs_cnt, cmp_cnt, sts_burst_cnt);
    end
    checks++; if (sts_abort !== 1'b1 || done_cnt !== 1) begin failures++;
      $display("FAIL abort_end: abort=%b done=%0d want 1/1", sts_abort, done_cnt); end
    auto_cmp = 1'b0; cmd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int d0;
    clear_stats();
    start(32'h0000_1000, 32'h0000_3000, 32'h2000, 8'd15);
    checks++; if (sts_abort !== 1'b0) begin failures++;
      $display("FAIL rstmid_abort_clear: got %b want 0", sts_abort); end
    step();
    checks++; if (cmd_valid !== 1'b1 || cmd_len !== 8'd15) begin failures++;
      $display("FAIL rstmid_issue: valid=%b len=%0d want 1/15", cmd_valid, cmd_len); end
    lb_rst = 1'b1;
    step();
    checks++;
    if ({cmd_valid, sts_busy, sts_done, cmd_len} !== 11'd0 || cmd_src_addr !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_outputs: valid=%b busy=%b done=%b len=%0d src=%h want all 0",
               cmd_valid, sts_busy, sts_done, cmd_len, cmd_src_addr);
    end
    lb_rst = 1'b0;
    d0 = done_cnt;
    repeat (6) step();
    checks++; if (done_cnt !== d0 || sts_busy !== 1'b0) begin failures++;
      $display("FAIL rstmid_no_done: done=%0d busy=%b want %0d/0", done_cnt, sts_busy, d0); end
  endtask

  initial begin
    test_reset();
    test_4k_split();
    test_4k_cross();
    test_outstanding();
    test_zero_len();
    test_err_simul();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdma_burst_seq.md
Name: cdma_burst_seq

Overview:
Sequencer for the CDMA engine. It takes a transfer descriptor from the local-bus config register block: source address, destination address, byte count and burst length (reset default 255). It splits the transfer into AXI-legal burst commands for the datamover, limits the number of in-flight bursts, and collects completions. It reports busy, done, error and counter status back to the register block for readback.

Parameters:
ADDR_WDTH, 32, source/destination address width
LEN_WDTH, 32, byte-count width
BEAT_BYTES, 32, bytes per AXI beat (power of 2, at most 4096)
MAX_OUTSTD, 4, maximum issued-but-uncompleted bursts (1..15)
DGBCNT_WDTH, 32, status counter width

Ports:
lb_clk  in  1  single clock for all logic
lb_rst  in  1  synchronous reset, active-high
cfg_start  in  1  one-cycle pulse; samples all cfg_* inputs
cfg_abort  in  1  one-cycle pulse; stops issuing new bursts
cfg_src_addr  in  ADDR_WDTH  source byte address
cfg_dst_addr  in  ADDR_WDTH  destination byte address
cfg_xfer_bytes  in  LEN_WDTH  total bytes to move
cfg_burst_len  in  8  maximum beats per burst minus 1
cmd_valid  out  1  burst command valid
cmd_ready  in  1  datamover accepts the command
cmd_src_addr  out  ADDR_WDTH  burst source address
cmd_dst_addr  out  ADDR_WDTH  burst destination address
cmd_len  out  8  burst beats minus 1
cmp_valid  in  1  one burst completed (one-cycle pulse per burst)
cmp_err  in  1  error on the completing burst; qualified by cmp_valid
sts_busy  out  1  transfer in progress
sts_done  out  1  one-cycle pulse at transfer end
sts_err  out  1  sticky error flag; cleared by cfg_start
sts_abort  out  1  sticky flag, last transfer was aborted; cleared by cfg_start
sts_burst_cnt  out  DGBCNT_WDTH  bursts accepted this transfer
sts_err_cnt  out  DGBCNT_WDTH  error completions this transfer

Behaviour:
- Reset: every output is 0; state is IDLE; the outstanding counter is 0. A reset mid-transfer drops the transfer immediately with no done pulse, and cmd_valid deasserts in the next cycle.
- Descriptor alignment: low log2(BEAT_BYTES) bits of both addresses and of cfg_xfer_bytes are forced to 0. remaining_beats = cfg_xfer_bytes / BEAT_BYTES.
- States: IDLE, CALC, ISSUE, WAIT, DONE.
- IDLE: on cfg_start, latch the descriptor, clear the counters, sts_err and sts_abort, then go to CALC. cfg_start in any other state is ignored. cfg_abort in IDLE is ignored.
- CALC (1 cycle): compute beats = min(remaining_beats, cfg_burst_len+1, (4096 - src[11:0])/BEAT_BYTES, (4096 - dst[11:0])/BEAT_BYTES).
  - No burst may cross a 4 KB boundary on either side.
  - If remaining_beats is 0, go to DONE.
- ISSUE: cmd_valid=1 with stable address and length until cmd_ready. cmd_valid therefore first rises 2 cycles after cfg_start is sampled.
- On the ISSUE handshake:
  - Advance both addresses by beats*BEAT_BYTES and subtract beats from remaining_beats.
  - sts_burst_cnt increments by 1 and outstanding increments by 1.
  - If remaining_beats > 0, no abort is pending and outstanding (after update) < MAX_OUTSTD, go to CALC; otherwise go to WAIT.
- WAIT:
  - If outstanding < MAX_OUTSTD, remaining_beats > 0 and no abort is pending, go to CALC.
  - Else if outstanding is 0, go to DONE.
- Completions, in any non-IDLE state: cmp_valid decrements outstanding. cmp_valid together with cmp_err sets sts_err and increments sts_err_cnt. Errors do not stop the transfer.
- Same-cycle handshake and cmp_valid: outstanding is unchanged.
- cmp_valid with outstanding 0, or in IDLE: ignored for the count; sets sts_err.
- cfg_abort in CALC, ISSUE or WAIT: sets the abort-pending flag and sts_abort.
  - A command already presented in ISSUE is held until accepted; no valid retraction.
  - No further bursts are issued; outstanding completions drain, then DONE.
- DONE (1 cycle): sts_done=1, then IDLE.
- sts_busy = 1 in every state except IDLE.
- Counters saturate at all-ones.

Test Plan:
1. Burst/4 KB split: BEAT_BYTES=32, src=0x3000_0000, dst=0x1000_0000, bytes=0x4000, burst_len=255, cmd_ready=1, cmp_valid 5 cycles after each command -> 4 commands, each cmd_len=127, src 0x3000_0000/1000/2000/3000 with matching dst; sts_done once; sts_burst_cnt=4; sts_err=0.
2. 4 KB crossing: src=0x3000_0F80, dst=0x1000_0000, bytes=0x200 -> cmd1 len=3 @0x3000_0F80; cmd2 len=11 @0x3000_1000, dst 0x1000_0080.
3. Outstanding limit: bytes=0x2000, burst_len=15 (16 commands), completions withheld -> exactly 4 accepted, cmd_valid low, sts_busy=1; one cmp_valid -> 5th command appears within 3 cycles.
4. Zero length: bytes=0x1F -> no cmd_valid; sts_done 2 cycles after start; sts_burst_cnt=0.
5. Error and simultaneity: cmp_err on the 2nd of 4 completions, with a completion coincident with a handshake -> all 4 bursts complete; sts_err=1, sts_err_cnt=1; outstanding never exceeds 4; done asserted.
6. Abort/reset: cfg_abort while cmd_valid=1 and cmd_ready=0 -> command held until accepted, no new commands, done after the last completion, sts_abort=1. Separately, lb_rst mid-transfer -> all outputs 0 next cycle, no done pulse.
